// File: rtl/fifo_falling_if.sv
// Push/pop bus for the falling-edge event FIFO between peripheral logic and the processor.
// The master side pushes and pops; the slave side is the FIFO itself.
interface fifo_falling_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             write_enable;
  logic [WIDTH-1:0] data_write;
  logic             read_enable;
  logic             clear_flags;
  logic [WIDTH-1:0] data_read;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_enable, data_write, read_enable, clear_flags,
    input  data_read, empty, full, count, overflow, underflow
  );

  modport slave (
    input  write_enable, data_write, read_enable, clear_flags,
    output data_read, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_falling.sv
// Show-ahead FIFO whose state updates on the falling clock edge, so a rising-edge
// consumer always samples a value that has been stable for half a cycle.
module fifo_falling #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  fifo_falling_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  logic isEmpty;
  logic isFull;
  logic pushAcc;
  logic popAcc;
  logic pushRej;
  logic popRej;

  // Status decoded from registered state only; no input reaches an output combinationally.
  assign isEmpty = (count == '0);
  assign isFull  = (count == CW'(DEPTH));

  // A full FIFO still takes a push when a pop frees the head slot on the same edge.
  assign pushAcc = bus.write_enable && (!isFull || bus.read_enable);
  assign popAcc  = bus.read_enable && !isEmpty;
  assign pushRej = bus.write_enable && !pushAcc;
  assign popRej  = bus.read_enable && isEmpty;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushAcc) begin
        mem[wrPtr] <= bus.data_write;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (popAcc) rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(pushAcc) - CW'(popAcc);
    end
  end

  // Sticky error flags; a new rejection on the clearing edge keeps the flag set.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= pushRej || (overflow && !bus.clear_flags);
      underflow <= popRej  || (underflow && !bus.clear_flags);
    end
  end

  assign bus.data_read = isEmpty ? '0 : mem[rdPtr];
  assign bus.empty     = isEmpty;
  assign bus.full      = isFull;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_fifo_falling.sv
// Directed and table-driven checks for fifo_falling: ordering, boundary handshakes,
// sticky flags, asynchronous reset and pointer wrap against a reference queue.
module tb_fifo_falling;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fifo_falling_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_falling #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        cf;
    int          expCount;
    logic        expEmpty;
    logic        expFull;
    logic [31:0] expData;
    logic        expOvf;
    logic        expUdf;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic we, logic [31:0] wd, logic re, logic cf, int c,
                              logic e, logic f, logic [31:0] d, logic o, logic u);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.cf = cf;
    v.expCount = c; v.expEmpty = e; v.expFull = f; v.expData = d;
    v.expOvf = o; v.expUdf = u;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int c, input logic e, input logic f,
                          input logic [31:0] d, input logic o, input logic u);
    check({tag, ".count"},     64'(bus.count),     64'(c));
    check({tag, ".empty"},     64'(bus.empty),     64'(e));
    check({tag, ".full"},      64'(bus.full),      64'(f));
    check({tag, ".data_read"}, 64'(bus.data_read), 64'(d));
    check({tag, ".overflow"},  64'(bus.overflow),  64'(o));
    check({tag, ".underflow"}, 64'(bus.underflow), 64'(u));
  endtask

  // Drive inputs after the rising edge, let the falling edge act, then sample 1 time unit later.
  task automatic step(input logic we, input logic [31:0] wd, input logic re, input logic cf);
    @(posedge clk);
    bus.write_enable = we;
    bus.data_write   = wd;
    bus.read_enable  = re;
    bus.clear_flags  = cf;
    @(negedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.write_enable = 1'b0;
    bus.data_write   = '0;
    bus.read_enable  = 1'b0;
    bus.clear_flags  = 1'b0;
  endtask

  logic [31:0] refQ [$];
  logic [31:0] heads [8];

  initial begin
    idleInputs();
    reset = 1'b1;

    // Full/overflow/underflow table; after the AA write the contents are 22..88, AA.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 32'(8'h11 * (i + 1)), 0, 0, i + 1, 0, (i == 7), 32'h11, 0, 0));
    vecs.push_back(mk(1, 32'h99, 0, 0, 8, 0, 1, 32'h11, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 1, 8, 0, 1, 32'h11, 0, 0));
    vecs.push_back(mk(1, 32'h99, 0, 1, 8, 0, 1, 32'h11, 1, 0));
    vecs.push_back(mk(0, 32'h0,  0, 1, 8, 0, 1, 32'h11, 0, 0));
    vecs.push_back(mk(1, 32'hAA, 1, 0, 8, 0, 1, 32'h22, 0, 0));
    heads = '{32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'hAA, 32'h0};
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 32'h0, 1, 0, 7 - k, (k == 7), 0, heads[k], 0, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 32'h5, 1, 0, 1, 0, 0, 32'h5, 0, 1));
    vecs.push_back(mk(0, 32'h0, 0, 1, 1, 0, 0, 32'h5, 0, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 0, 0));

    repeat (2) @(posedge clk);
    #1 checkAll("reset_held", 0, 1, 0, 32'h0, 0, 0);
    reset = 1'b0;
    step(0, 32'h0, 0, 0);
    checkAll("reset_idle", 0, 1, 0, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].cf);
      checkAll($sformatf("v%0d", i), vecs[i].expCount, vecs[i].expEmpty, vecs[i].expFull,
               vecs[i].expData, vecs[i].expOvf, vecs[i].expUdf);
    end

    // Asynchronous reset with five entries and a raised flag, checked before any falling edge.
    step(0, 32'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i), 0, 0);
    checkAll("pre_reset", 5, 0, 0, 32'h100, 0, 1);
    @(posedge clk);
    bus.write_enable = 1'b1;
    bus.data_write   = 32'hDEAD;
    #1 reset = 1'b1;
    #1 checkAll("async_reset", 0, 1, 0, 32'h0, 0, 0);
    idleInputs();
    #1 reset = 1'b0;
    step(0, 32'h0, 0, 0);
    checkAll("post_reset", 0, 1, 0, 32'h0, 0, 0);

    // Pointer wrap against a reference queue with random simultaneous push/pop.
    for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
    checkAll("wrap_start", 0, 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      logic we, re, pushA, popA;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (i < 8)       begin we = 1'b1; re = (i >= 6); end
      else if (i >= 72) begin we = 1'b0; re = 1'b1; end
      wd = $urandom;
      pushA = we && (refQ.size() < DEPTH || re);
      popA  = re && refQ.size() != 0;
      if (popA)  void'(refQ.pop_front());
      if (pushA) refQ.push_back(wd);
      step(we, wd, re, 1'b1);
      check($sformatf("wrap%0d.count", i), 64'(bus.count), 64'(refQ.size()));
      check($sformatf("wrap%0d.head", i), 64'(bus.data_read),
            64'(refQ.size() != 0 ? refQ[0] : 32'h0));
      check($sformatf("wrap%0d.range", i), 64'(bus.count <= 4'(DEPTH)), 64'(1));
    end
    idleInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
